vga_fade_stage: RTL and testbench
=================================

# vga_fade_stage

Output stage placed directly downstream of the pixel colour generator in the demoscene top level. It consumes the 2-bit RGB, sync and visibility signals and produces the registered VGA pins. It blanks pixels outside the visible area and applies a frame-paced brightness fade. The fade runs as a looping fade-in / hold / fade-out / black sequence, using 2x2 ordered dithering to approximate intermediate brightness levels on 2-bit channels.

## Interface
Parameters:
- STEP_FRAMES, 8: frames per brightness step during fades (>=1)
- HOLD_FRAMES, 120: frames held at full brightness (>=1)
- BLACK_FRAMES, 30: frames held at level 0 (>=1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- visible  in  1  display-on from the sync generator
- hpos, vpos  in  10 each  current pixel coordinates
- hsync_in, vsync_in  in  1 each  sync from the sync generator, active high
- r_in, g_in, b_in  in  2 each  pixel colour
- fade_en  in  1  1 = run the fade sequence; 0 = full brightness, sequence frozen
- vga_r, vga_g, vga_b  out  2 each  registered colour
- hsync, vsync  out  1 each  registered sync
- level  out  3  current brightness level, 0..4

## Operation
- Frame tick: vsync_d registers vsync_in; tick = vsync_in & ~vsync_d (rising edge). Counting happens only on tick while fade_en = 1.
- FSM states are FADE_IN, HOLD, FADE_OUT and BLACK. frame_cnt is sized with clog2 of the largest parameter.
- FADE_IN, on tick:
  - if frame_cnt == STEP_FRAMES-1: frame_cnt <= 0 and level <= level+1; when the new level is 4, go to HOLD.
  - otherwise frame_cnt increments.
- HOLD, on tick: at frame_cnt == HOLD_FRAMES-1, frame_cnt <= 0 and go to FADE_OUT; otherwise frame_cnt increments.
- FADE_OUT: mirror of FADE_IN. level decrements; when the new level is 0, go to BLACK.
- BLACK, on tick: at frame_cnt == BLACK_FRAMES-1, frame_cnt <= 0 and go to FADE_IN.
- fade_en = 0: state, frame_cnt and level are frozen. The effective level L used by the datapath is 4; the `level` output still shows the frozen register. When fade_en returns to 1, the sequence resumes from the frozen point.
- Dither value d is 2 bits: d[1] = hpos[0] ^ vpos[0], d[0] = vpos[0]. This is the Bayer 2x2 pattern 0,2 / 3,1.
- Per channel c:
  - out = (c*L + d) >> 2, using 4-bit intermediates (max 3*4+3 = 15, no overflow, no clamp).
  - L = 4 reproduces c exactly. L = 0 gives 0.
- Blanking: if visible = 0, all colour outputs are 0 regardless of level.

## Timing
- Colour and sync outputs are registered. Each has exactly 1 cycle latency from the corresponding inputs, so sync and colour stay aligned.
- Level changes on the clock edge where tick is seen. The first pixel affected is the one sampled on the following edge.
- If tick and a fade_en 1->0 transition occur in the same cycle, the tick is ignored because fade_en is sampled low.
- Reset (asynchronous, any time including mid-frame) forces:
  - vga_r/g/b = 0, hsync = 0, vsync = 0, vsync_d = 0
  - state = FADE_IN, level = 0, frame_cnt = 0
- After reset release, the first vsync_in rising edge counts as a tick.
- vsync_in held high across reset release does not produce a tick until it falls and rises again.

## Test plan
- Reset mid-fade: assert reset while level = 3 and outputs are non-zero -> all outputs, including level, are 0 within the same cycle, before any clock edge; state = FADE_IN.
- Passthrough: fade_en = 0, visible = 1, r_in = 3, g_in = 2, b_in = 1 -> vga_r/g/b = 3/2/1 one cycle later for all hpos/vpos parities; hsync/vsync track the inputs with 1-cycle delay.
- Dither: force level = 2 (fade-in, fade_en = 1), c = 3 -> (hpos[0], vpos[0]) = (0,0)->1, (1,0)->2, (0,1)->2, (1,1)->1.
- Sequence timing with STEP_FRAMES = 2, HOLD_FRAMES = 3, BLACK_FRAMES = 2:
  - level goes 0->1->2->3->4 on ticks 2, 4, 6, 8
  - HOLD ends on tick 11; level reaches 0 on tick 19
  - BLACK ends on tick 21, then FADE_IN restarts
- Blanking: visible = 0 with c = 3 at level 4 -> colour outputs 0 and syncs still pass through.
- Freeze: fade_en = 0 for 10 ticks during FADE_OUT at level 2 -> level stays 2 and frame_cnt is unchanged; after re-enable, the next STEP_FRAMES ticks decrement level to 1.

Source files
------------

// File: rtl/vga_fade_stage.sv
// vga_fade_stage
// Final VGA output stage: registers colour and sync, blanks outside the
// visible area and scales the 2-bit colour channels by a frame-paced
// brightness level (0..4).  Intermediate levels are approximated with a
// 2x2 ordered (Bayer) dither so that 2-bit channels still show a smooth
// ramp.  The fade loops FADE_IN -> HOLD -> FADE_OUT -> BLACK.
module vga_fade_stage #(
    parameter int STEP_FRAMES  = 8,   // frames per brightness step while fading
    parameter int HOLD_FRAMES  = 120, // frames held at full brightness
    parameter int BLACK_FRAMES = 30   // frames held at level 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       visible,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [1:0] r_in,
    input  logic [1:0] g_in,
    input  logic [1:0] b_in,
    input  logic       fade_en,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] level
);

    // ------------------------------------------------------------------
    // Frame counter sizing: wide enough for the largest phase length.
    // ------------------------------------------------------------------
    localparam int MAX_SH = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
    localparam int MAX_P  = (MAX_SH > BLACK_FRAMES) ? MAX_SH : BLACK_FRAMES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLACK_LAST = CNT_W'(BLACK_FRAMES - 1);

    localparam logic [2:0] LEVEL_FULL = 3'd4;
    localparam int         NUM_CH     = 3;

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        HOLD     = 2'd1,
        FADE_OUT = 2'd2,
        BLACK    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Frame tick detection
    // ------------------------------------------------------------------
    logic vsync_prev_q, vsync_prev_d;
    // armed_q stays low after reset until vsync_in has been seen low, so a
    // vsync that is already high when reset releases is not a frame edge.
    logic armed_q, armed_d;
    logic tick;
    logic count_en;

    // Next-state for the edge detector and the arming flag.
    always_comb begin
        vsync_prev_d = vsync_in;
        armed_d      = armed_q | ~vsync_in;
        tick         = vsync_in & ~vsync_prev_q & armed_q;
        count_en     = tick & fade_en;
    end

    // ------------------------------------------------------------------
    // Fade sequencer
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]       level_q, level_d;

    // Sequencer next-state: advances only on an enabled frame tick, so
    // dropping fade_en freezes state, frame count and level in place.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        level_d     = level_q;
        if (count_en) begin
            case (state_q)
                FADE_IN: begin
                    if (frame_cnt_q == STEP_LAST) begin
                        frame_cnt_d = '0;
                        level_d     = level_q + 3'd1;
                        if (level_q == 3'd3) begin
                            state_d = HOLD;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (frame_cnt_q == HOLD_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = FADE_OUT;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (frame_cnt_q == STEP_LAST) begin
                        frame_cnt_d = '0;
                        level_d     = level_q - 3'd1;
                        if (level_q == 3'd1) begin
                            state_d = BLACK;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                BLACK: begin
                    if (frame_cnt_q == BLACK_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = FADE_IN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = FADE_IN;
                    frame_cnt_d = '0;
                    level_d     = '0;
                end
            endcase
        end
    end

    // Sequencer and tick-detector registers; reset starts a fresh fade-in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FADE_IN;
            frame_cnt_q  <= '0;
            level_q      <= '0;
            vsync_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            level_q      <= level_d;
            vsync_prev_q <= vsync_prev_d;
            armed_q      <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Colour datapath
    // ------------------------------------------------------------------
    logic [2:0]              eff_level;
    logic [1:0]              dither;
    logic [NUM_CH-1:0][1:0]  chan_in;
    logic [NUM_CH-1:0][1:0]  chan_d;
    logic [NUM_CH-1:0][1:0]  chan_q;

    // Effective level and dither threshold for the current pixel.  With the
    // fade disabled the picture is shown at full brightness while the level
    // register keeps its frozen value.  Dither is Bayer 2x2: 0,2 / 3,1.
    always_comb begin
        eff_level = fade_en ? level_q : LEVEL_FULL;
        dither    = {hpos[0] ^ vpos[0], vpos[0]};
    end

    assign chan_in[0] = r_in;
    assign chan_in[1] = g_in;
    assign chan_in[2] = b_in;

    // Per-channel scale: (c*L + d) >> 2.  Max 3*4+3 = 15, so 4 bits never
    // overflow; L = 4 returns c exactly and L = 0 always returns 0.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        logic [3:0] scaled;
        logic [3:0] dithered;
        assign scaled     = 4'(chan_in[gi]) * 4'(eff_level);
        assign dithered   = scaled + {2'b00, dither};
        assign chan_d[gi] = visible ? dithered[3:2] : 2'b00;
    end

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;

    // Syncs pass through with the same single-cycle delay as colour.
    always_comb begin
        hsync_d = hsync_in;
        vsync_d = vsync_in;
    end

    // Output pin registers; reset drives every pin low immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q  <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            chan_q  <= chan_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga_r = chan_q[0];
    assign vga_g = chan_q[1];
    assign vga_b = chan_q[2];
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign level = level_q;

    // Only the parity of the coordinates drives the dither pattern.
    logic unused_coord_bits;
    assign unused_coord_bits = ^{hpos[9:1], vpos[9:1]};

endmodule

// File: tb/tb_vga_fade_stage.sv
// Testbench for vga_fade_stage: randomized frames checked every cycle
// against a tick-count based reference model, plus literal checkpoints.
module tb_vga_fade_stage;

    localparam int S      = 2;
    localparam int H      = 3;
    localparam int B      = 2;
    localparam int PERIOD = 8 * S + H + B;
    localparam int FLEN   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       visible;
    logic [9:0] hpos, vpos;
    logic       hsync_in, vsync_in;
    logic [1:0] r_in, g_in, b_in;
    logic       fade_en;
    logic [1:0] vga_r, vga_g, vga_b;
    logic       hsync, vsync;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    // Model state: number of enabled frame ticks since reset
    int  nticks   = 0;
    logic vs_prev  = 1'b0;
    logic seen_low = 1'b0;

    vga_fade_stage #(
        .STEP_FRAMES (S),
        .HOLD_FRAMES (H),
        .BLACK_FRAMES(B)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .visible (visible),
        .hpos    (hpos),
        .vpos    (vpos),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .r_in    (r_in),
        .g_in    (g_in),
        .b_in    (b_in),
        .fade_en (fade_en),
        .vga_r   (vga_r),
        .vga_g   (vga_g),
        .vga_b   (vga_b),
        .hsync   (hsync),
        .vsync   (vsync),
        .level   (level)
    );

    always #5 clk = ~clk;

    // Brightness level after n enabled ticks, from the phase lengths.
    function automatic int level_of(input int n);
        int m;
        m = n % PERIOD;
        if (m < 4 * S)             return m / S;
        else if (m < 4 * S + H)    return 4;
        else if (m < 8 * S + H)    return 4 - (m - 4 * S - H) / S;
        else                       return 0;
    endfunction

    function automatic int scale(input int c, input int l, input int d);
        return (c * l + d) / 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and per-cycle compare
    initial begin
        int eff, d, er, eg, eb, ehs, evs;
        forever begin
            @(posedge clk);
            if (reset) begin
                nticks   = 0;
                vs_prev  = 1'b0;
                seen_low = 1'b0;
            end else begin
                eff = fade_en ? level_of(nticks) : 4;
                d   = 2 * int'(hpos[0] ^ vpos[0]) + int'(vpos[0]);
                er  = visible ? scale(int'(r_in), eff, d) : 0;
                eg  = visible ? scale(int'(g_in), eff, d) : 0;
                eb  = visible ? scale(int'(b_in), eff, d) : 0;
                ehs = int'(hsync_in);
                evs = int'(vsync_in);
                if (vsync_in && !vs_prev && seen_low && fade_en) nticks++;
                if (!vsync_in) seen_low = 1'b1;
                vs_prev = vsync_in;
                #1;
                if (!reset) begin
                    chk("cyc_vga_r", int'(vga_r), er);
                    chk("cyc_vga_g", int'(vga_g), eg);
                    chk("cyc_vga_b", int'(vga_b), eb);
                    chk("cyc_hsync", int'(hsync), ehs);
                    chk("cyc_vsync", int'(vsync), evs);
                    chk("cyc_level", int'(level), level_of(nticks));
                end
            end
        end
    end

    // One frame: vsync high for two cycles, random pixels afterwards.
    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < FLEN; c++) begin
                @(negedge clk);
                vsync_in = (c < 2);
                hsync_in = 1'($urandom);
                hpos     = 10'($urandom);
                vpos     = 10'($urandom);
                r_in     = 2'($urandom);
                g_in     = 2'($urandom);
                b_in     = 2'($urandom);
                visible  = ($urandom_range(0, 3) != 0);
            end
            $display("frame fade_en=%0d ticks=%0d level=%0d", fade_en, nticks, level);
        end
    endtask

    // Drive one pixel and wait until its registered result is visible.
    task automatic px(input logic h0, input logic v0, input logic vis,
                      input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                      input logic hs);
        @(negedge clk);
        hpos     = {9'($urandom), h0};
        vpos     = {9'($urandom), v0};
        visible  = vis;
        r_in     = r;
        g_in     = g;
        b_in     = b;
        hsync_in = hs;
        vsync_in = 1'b0;
        @(posedge clk);
        #1;
        $display("pixel h0=%0d v0=%0d vis=%0d rgb=%0d/%0d/%0d -> %0d/%0d/%0d lvl=%0d",
                 h0, v0, vis, r, g, b, vga_r, vga_g, vga_b, level);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fade_en = 1'b0; visible = 1'b0;
        hpos = '0; vpos = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_vga_r", int'(vga_r), 0);
        chk("rst_hsync", int'(hsync), 0);
        chk("rst_level", int'(level), 0);

        // Model pins
        chk("model_t2", level_of(2), 1);
        chk("model_t11", level_of(11), 4);
        chk("model_t19", level_of(19), 0);
        chk("model_t23", level_of(23), 1);

        @(negedge clk);
        reset   = 1'b0;
        fade_en = 1'b1;

        run_frames(2);  chk("seq_t2_level", int'(level), 1);
        run_frames(2);  chk("seq_t4_level", int'(level), 2);

        // Dither at level 2 with c = 3
        px(1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 2'd3, 1'b0); chk("dith_00", int'(vga_r), 1);
        px(1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 2'd3, 1'b0); chk("dith_10", int'(vga_r), 2);
        px(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 1'b0); chk("dith_01", int'(vga_g), 2);
        px(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 1'b0); chk("dith_11", int'(vga_b), 1);

        run_frames(4);  chk("seq_t8_level", int'(level), 4);
        run_frames(3);  chk("seq_t11_level", int'(level), 4);
        run_frames(2);  chk("seq_t13_level", int'(level), 3);
        run_frames(2);  chk("seq_t15_level", int'(level), 2);

        // Freeze during fade-out at level 2, with passthrough colour
        fade_en = 1'b0;
        run_frames(10); chk("frz_level", int'(level), 2);
        for (int p = 0; p < 4; p++) begin
            px(1'(p), 1'(p >> 1), 1'b1, 2'd3, 2'd2, 2'd1, 1'(p));
            chk("pass_r", int'(vga_r), 3);
            chk("pass_g", int'(vga_g), 2);
            chk("pass_b", int'(vga_b), 1);
            chk("pass_hs", int'(hsync), p & 1);
        end
        fade_en = 1'b1;
        run_frames(1);  chk("resume_1", int'(level), 2);
        run_frames(1);  chk("resume_2", int'(level), 1);
        run_frames(2);  chk("seq_t19_level", int'(level), 0);
        run_frames(2);  chk("seq_t21_level", int'(level), 0);
        run_frames(2);  chk("seq_t23_level", int'(level), 1);
        run_frames(6);  chk("seq_t29_level", int'(level), 4);

        // Blanking at full level
        px(1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 2'd3, 1'b1);
        chk("blank_r", int'(vga_r), 0);
        chk("blank_b", int'(vga_b), 0);
        chk("blank_hs", int'(hsync), 1);

        run_frames(5);  chk("seq_t34_level", int'(level), 3);

        // Asynchronous reset mid-fade with non-zero outputs
        px(1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 2'd3, 1'b1);
        chk("pre_rst_r", int'(vga_r), 2);
        @(negedge clk);
        reset    = 1'b1;
        vsync_in = 1'b1;
        #1;
        chk("arst_r", int'(vga_r), 0);
        chk("arst_g", int'(vga_g), 0);
        chk("arst_b", int'(vga_b), 0);
        chk("arst_hs", int'(hsync), 0);
        chk("arst_level", int'(level), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // vsync held high across release must not count
        repeat (3) @(negedge clk);
        vsync_in = 1'b0;
        repeat (2) @(negedge clk);
        run_frames(1);  chk("held_hi_t1", int'(level), 0);
        run_frames(1);  chk("held_hi_t2", int'(level), 1);

        // Random fade_en per frame
        for (int f = 0; f < 40; f++) begin
            @(negedge clk);
            fade_en = ($urandom_range(0, 3) != 0);
            run_frames(1);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
